// File: rtl/float_add_pipe.sv
// Three-stage floating-point adder (align, add, normalise/round) with valid/ready flow control
// and a running-accumulate mode. Define FLOAT_ADD_SAT_EN to saturate results on exponent overflow.
module float_add_pipe #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned FTZ_EXP = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 acc_mode,
    input  logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    // {00,1,man} followed by MAN_W guard bits
    localparam int unsigned SW = 2 * MAN_W + 3;
    localparam int unsigned PW = $clog2(SW);
    localparam int unsigned EW = EXP_W + 3;

    logic             stall;
    logic             busy;
    logic             accept;

    logic             v1_q, acc1_q;
    logic [SW-1:0]    ma1_q, mb1_q;
    logic [EXP_W-1:0] e1_q;

    logic             v2_q, acc2_q, sgn2_q;
    logic [SW-1:0]    mag2_q;
    logic [EXP_W-1:0] e2_q;

    logic             v3_q;
    logic [W-1:0]     sum_q;
    logic [W-1:0]     acc_q;

    assign stall     = v3_q && !out_ready;
    assign busy      = (v1_q && acc1_q) || (v2_q && acc2_q);
    assign in_ready  = !stall && !(acc_mode && busy);
    assign accept    = in_valid && in_ready;
    assign out_valid = v3_q;
    assign sum       = sum_q;

    function automatic logic [SW-1:0] asr_sat(input logic [SW-1:0] x, input logic [EXP_W:0] sh);
        if (32'(sh) >= SW) begin
            return {SW{x[SW-1]}};
        end
        return $unsigned($signed(x) >>> sh);
    endfunction

    // Stage 1: operand select, flush, two's-complement mantissas and alignment
    logic [W-1:0]     op_b;
    logic [EXP_W-1:0] ea, eb, e1_d;
    logic [SW-1:0]    ma_ext, mb_ext, ma1_d, mb1_d;
    logic [EXP_W:0]   diff, shamt;

    always_comb begin
        op_b   = acc_mode ? (acc_clear ? '0 : acc_q) : b;
        ea     = a[W-2 -: EXP_W];
        eb     = op_b[W-2 -: EXP_W];
        ma_ext = {2'b00, 1'b1, a[MAN_W-1:0], {MAN_W{1'b0}}};
        mb_ext = {2'b00, 1'b1, op_b[MAN_W-1:0], {MAN_W{1'b0}}};
        // A flushed operand also drops its exponent so the other one passes through unshifted
        if (ea < EXP_W'(FTZ_EXP)) begin
            ea     = '0;
            ma_ext = '0;
        end
        if (eb < EXP_W'(FTZ_EXP)) begin
            eb     = '0;
            mb_ext = '0;
        end
        if (a[W-1]) ma_ext = -ma_ext;
        if (op_b[W-1]) mb_ext = -mb_ext;

        diff = {1'b0, ea} - {1'b0, eb};
        if (!diff[EXP_W]) begin
            e1_d  = ea;
            shamt = diff;
            ma1_d = ma_ext;
            mb1_d = asr_sat(mb_ext, shamt);
        end else begin
            e1_d  = eb;
            shamt = -diff;
            ma1_d = asr_sat(ma_ext, shamt);
            mb1_d = mb_ext;
        end
    end

    // Stage 2: signed add, sign and magnitude
    logic [SW-1:0] raw2, mag2_d;

    assign raw2   = ma1_q + mb1_q;
    assign mag2_d = raw2[SW-1] ? -raw2 : raw2;

    // Stage 3: leading-one normalise, round to nearest even, flush and overflow handling
    logic [PW-1:0] lead, offset;
    logic [SW-1:0] norm;
    logic [MAN_W:0] man_rnd;
    logic [EW-1:0] exp_base, exp_fin;
    logic          round_up, underflow;
    logic [W-1:0]  res;

    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(SW); i++) begin
            if (mag2_q[i]) lead = PW'(i);
        end
        offset    = PW'(SW - 1) - lead;
        norm      = mag2_q << offset;
        round_up  = norm[SW-2-MAN_W] && ((|norm[SW-3-MAN_W:0]) || norm[SW-1-MAN_W]);
        man_rnd   = {1'b0, norm[SW-2 -: MAN_W]} + (MAN_W+1)'(round_up);
        exp_base  = EW'(e2_q) + EW'(2);
        underflow = exp_base <= EW'(offset);
        exp_fin   = exp_base - EW'(offset) + EW'(man_rnd[MAN_W]);
        res       = {sgn2_q, exp_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
`ifdef FLOAT_ADD_SAT_EN
        if (exp_fin >= EW'((1 << EXP_W) - 1)) begin
            res = {sgn2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
`endif
        // norm MSB is clear only for a zero magnitude
        if (!norm[SW-1] || underflow || exp_fin < EW'(FTZ_EXP)) begin
            res = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            acc1_q <= 1'b0;
            ma1_q  <= '0;
            mb1_q  <= '0;
            e1_q   <= '0;
            v2_q   <= 1'b0;
            acc2_q <= 1'b0;
            sgn2_q <= 1'b0;
            mag2_q <= '0;
            e2_q   <= '0;
            v3_q   <= 1'b0;
            sum_q  <= '0;
            acc_q  <= '0;
        end else if (!stall) begin
            v1_q <= accept;
            if (accept) begin
                ma1_q  <= ma1_d;
                mb1_q  <= mb1_d;
                e1_q   <= e1_d;
                acc1_q <= acc_mode;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                mag2_q <= mag2_d;
                sgn2_q <= raw2[SW-1];
                e2_q   <= e1_q;
                acc2_q <= acc1_q;
            end
            v3_q <= v2_q;
            if (v2_q) begin
                sum_q <= res;
                if (acc2_q) acc_q <= res;
            end
        end
    end

endmodule

// File: tb/tb_float_add_pipe.sv
// Bench for float_add_pipe: directed cases plus randomized streams against an exact-arithmetic
// reference model (sum computed on integers, then rounded to nearest even).
module tb_float_add_pipe;

    localparam int FTZ = 10;
`ifdef FLOAT_ADD_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7F7FFFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h7FFFFFFF;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc_mode;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;

    int          tests;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] acc_model;
    logic        fired;
    logic        last_ov;
    logic        last_ir;

    float_add_pipe #(
        .EXP_W  (8),
        .MAN_W  (23),
        .FTZ_EXP(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .acc_mode (acc_mode),
        .acc_clear(acc_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact sum on integers, then round to nearest even; valid when exponents differ by <= 23
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        longint mx, my, s, mag, q, rem, half;
        int     ex, ey, e0, p, r, e;
        logic   sg;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex < FTZ) ? 0 : longint'({1'b1, x[22:0]});
        my = (ey < FTZ) ? 0 : longint'({1'b1, y[22:0]});
        if (x[31]) mx = -mx;
        if (y[31]) my = -my;
        if (mx == 0) e0 = ey;
        else if (my == 0) e0 = ex;
        else e0 = (ex < ey) ? ex : ey;
        s = 0;
        if (mx != 0) s += mx <<< (ex - e0);
        if (my != 0) s += my <<< (ey - e0);
        if (s == 0) return 32'h0;
        sg  = (s < 0);
        mag = sg ? -s : s;
        p   = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        if (p > 23) begin
            r    = p - 23;
            q    = mag >> r;
            rem  = mag - (q << r);
            half = 64'sd1 << (r - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                r++;
            end
            e = e0 + r;
        end else begin
            q = mag << (23 - p);
            e = e0 - (23 - p);
        end
        if (e < FTZ || e <= 0) return 32'h0;
`ifdef FLOAT_ADD_SAT_EN
        if (e >= 255) return {sg, 8'hFE, 23'h7FFFFF};
`endif
        return {sg, 8'(e), 23'(q)};
    endfunction

    task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
        int ea, eb;
        ea = int'($urandom_range(12, 250));
        eb = ea + int'($urandom_range(0, 46)) - 23;
        if (eb > 254) eb = 254;
        if (eb < 0) eb = 0;
        x = {1'($urandom), 8'(ea), 23'($urandom)};
        y = {1'($urandom), 8'(eb), 23'($urandom)};
        case ($urandom_range(0, 15))
            0: y = {y[31], 8'($urandom_range(0, 9)), y[22:0]};
            1: y = x ^ 32'h8000_0000;
            2: y = {y[31], x[30:23], y[22:0]};
            default: ;
        endcase
    endtask

    // Called at a falling edge with inputs set; records transfers due on the next rising edge
    task automatic tick();
        logic [31:0] opb;
        logic [31:0] e;
        #1;
        last_ov = out_valid;
        last_ir = in_ready;
        fired   = in_valid && in_ready;
        if (out_valid && out_ready) obs_q.push_back(sum);
        if (fired) begin
            opb = acc_mode ? (acc_clear ? 32'h0 : acc_model) : b;
            e   = ref_add(a, opb);
            if (acc_mode) acc_model = e;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        while (!fired && n < 20) begin
            tick();
            n++;
        end
        if (!fired) begin
            tests++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic drain(input int n);
        int c = 0;
        in_valid = 1'b0;
        while (obs_q.size() < n && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests++;
        if (sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_sum: got %h expected 00000000", sum);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        acc_model = 32'h0;
    endtask

    task automatic test_basic();
        logic got_rdy;
        logic seen = 1'b0;
        int   lat = 0;
        out_ready = 1'b1;
        acc_mode  = 1'b0;
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        #1;
        got_rdy = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        while (lat < 10 && !seen) begin
            lat++;
            #1;
            seen = out_valid;
            if (!seen) @(negedge clk);
        end
        tests++;
        if (got_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready: got %b expected 1", got_rdy);
        end
        tests++;
        if (!seen || lat != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", seen ? lat : -1);
        end
        tests++;
        if (sum !== 32'h40000000) begin
            errors++;
            $display("FAIL basic_sum: got %h expected 40000000", sum);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [8];
        logic [31:0] tb_v [8];
        logic [31:0] te [8];
        ta   = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                 32'h3F800001, 32'h7F7FFFFF, 32'h04800000, 32'hC0000000};
        tb_v = '{32'h3F800000, 32'hBF800000, 32'h04800000, 32'h33800000,
                 32'h33800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000};
        te   = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                 32'h3F800002, OVF_EXP,      32'h3F800000, 32'hBF800000};
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b1;
        acc_mode  = 1'b0;
        for (int i = 0; i < 8; i++) send(ta[i], tb_v[i]);
        drain(8);
        tests++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL directed_count: got %0d expected 8", obs_q.size());
        end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, obs_q[i], te[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        int i = 0;
        int c = 0;
        exp_q.delete();
        obs_q.delete();
        acc_mode = 1'b0;
        for (int k = 0; k < 8; k++) gen_pair(pa[k], pb[k]);
        while (i < 8 && c < 100) begin
            out_ready = !(c >= 4 && c < 9);
            a = pa[i];
            b = pb[i];
            in_valid = 1'b1;
            tick();
            if (!out_ready && last_ov) begin
                tests++;
                if (last_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, last_ir);
                end
            end
            if (fired) i++;
            c++;
        end
        out_ready = 1'b1;
        drain(8);
        tests++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 8", obs_q.size());
        end
        for (int k = 0; k < 8 && k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int n = 0;
        int cyc = 0;
        logic [31:0] x, y;
        exp_q.delete();
        obs_q.delete();
        acc_clear = 1'b1;
        acc_mode  = 1'b0;
        gen_pair(x, y);
        a = x;
        b = y;
        while (n < 200 && cyc < 5000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 8);
            tick();
            if (fired) begin
                n++;
                gen_pair(x, y);
                a = x;
                b = y;
                acc_mode = ($urandom_range(0, 7) == 0);
            end
            cyc++;
        end
        acc_mode  = 1'b0;
        out_ready = 1'b1;
        drain(exp_q.size());
        tests++;
        if (obs_q.size() != exp_q.size() || n != 200) begin
            errors++;
            $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [31:0] vals [3];
        logic [31:0] want [3];
        int k = 0;
        int cyc = 0;
        int last = 0;
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000};
        want = '{32'h3F800000, 32'h40400000, 32'h40C00000};
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b1;
        acc_mode  = 1'b1;
        acc_clear = 1'b1;
        a = vals[0];
        b = 32'h41200000;
        in_valid = 1'b1;
        while (k < 3 && cyc < 50) begin
            tick();
            if (fired) begin
                if (k > 0) begin
                    tests++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL acc_gap_%0d: got %0d expected 3", k, cyc - last);
                    end
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    a = vals[k];
                    acc_clear = 1'b0;
                end
            end
            cyc++;
        end
        acc_mode = 1'b0;
        drain(3);
        tests++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL acc_count: got %0d expected 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== want[i]) begin
                errors++;
                $display("FAIL acc_sum_%0d: got %h expected %h", i, obs_q[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        exp_q.delete();
        obs_q.delete();
        out_ready = 1'b0;
        acc_mode  = 1'b0;
        send(32'h3F800000, 32'h3F800000);
        send(32'h40000000, 32'h3F800000);
        send(32'h40400000, 32'h3F800000);
        in_valid = 1'b0;
        #2;
        tests++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_out_valid: got %b expected 1", out_valid);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        obs_q.delete();
        acc_model = 32'h0;
        out_ready = 1'b1;
        repeat (10) tick();
        tests++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_results: got %0d expected 0", obs_q.size());
        end
        acc_mode  = 1'b1;
        acc_clear = 1'b0;
        send(32'h3F800000, 32'h0);
        acc_mode = 1'b0;
        drain(1);
        tests++;
        if (obs_q.size() != 1 || obs_q[0] !== 32'h3F800000) begin
            errors++;
            $display("FAIL acc_after_reset: got %h expected 3f800000",
                     obs_q.size() > 0 ? obs_q[0] : 32'hXXXXXXXX);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests     = 0;
        errors    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        acc_mode  = 1'b0;
        acc_clear = 1'b0;
        out_ready = 1'b1;
        acc_model = 32'h0;
        fired     = 1'b0;
        last_ov   = 1'b0;
        last_ir   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_random();
        test_accumulate();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
